// File: rtl/gnrc_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ valid/ready requesters.
// Tracks RAM read latency so each read response strobes only its issuer.
module gnrc_ram_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 32,
    parameter int AW         = 10,
    parameter int DELAY      = 1,
    parameter int BYTE_WRITE = 0,
    localparam int WW        = (BYTE_WRITE != 0) ? DW / 8 : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*WW-1:0] req_we_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]   rsp_valid_o,
    output logic [DW-1:0]     rsp_rdata_o,
    output logic              busy_o,
    output logic              ram_en_o,
    output logic [WW-1:0]     ram_we_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic [DW-1:0]     ram_din_o,
    input  logic [DW-1:0]     ram_dout_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (DELAY < 1) begin : g_bad_delay
        $error("gnrc_ram_arbiter: DELAY must be >= 1");
    end
    if (NREQ < 2) begin : g_bad_nreq
        $error("gnrc_ram_arbiter: NREQ must be >= 2");
    end
    if (BYTE_WRITE != 0 && (DW % 8) != 0) begin : g_bad_dw
        $error("gnrc_ram_arbiter: BYTE_WRITE requires DW to be a multiple of 8");
    end

    // Pointer arithmetic modulo NREQ, so non-power-of-2 counts wrap at NREQ-1.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] valid_eff;
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic            is_rd;

    logic [DELAY-1:0] rd_pipe;
    logic [NREQ-1:0]  id_pipe [DELAY];

    assign valid_eff = rst_i ? '0 : req_valid_i;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        grant_oh    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && valid_eff[wrap_idx(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr, k);
            end
        end
        if (grant_found) grant_oh[grant_idx] = 1'b1;
    end

    assign req_ready_o = grant_oh;
    assign ram_en_o    = |valid_eff;
    assign ram_we_o    = grant_found ? req_we_i[int'(grant_idx)*WW +: WW] : '0;
    assign ram_addr_o  = req_addr_i[int'(grant_idx)*AW +: AW];
    assign ram_din_o   = req_wdata_i[int'(grant_idx)*DW +: DW];
    assign is_rd       = grant_found && !(|ram_we_o);

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr  <= '0;
            rd_pipe <= '0;
        end else begin
            if (grant_found) rr_ptr <= wrap_idx(grant_idx, 1);
            rd_pipe[0] <= is_rd;
            for (int i = 1; i < DELAY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // NOTE: the id stages are qualified by rd_pipe, so only the control bits need a reset.
    always_ff @(posedge clk_i) begin
        id_pipe[0] <= grant_oh;
        for (int i = 1; i < DELAY; i++) id_pipe[i] <= id_pipe[i-1];
    end

    assign rsp_valid_o = (rd_pipe[DELAY-1] && !rst_i) ? id_pipe[DELAY-1] : '0;
    assign rsp_rdata_o = ram_dout_i;
    assign busy_o      = (|rd_pipe) && !rst_i;

endmodule

// File: tb/tb_gnrc_ram_arbiter.sv
// Bench for gnrc_ram_arbiter: a 4-requester/DELAY=1 instance driven from a vector table,
// and a 3-requester/DELAY=2/byte-write instance driven by hand-written sequences.
module tb_gnrc_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance 0: NREQ=4, DELAY=1, word write ----------------
    logic        rst0 = 1'b1;
    logic [3:0]  valid0 = '0, ready0, rsp0, we0 = '0;
    logic [39:0] addr0 = '0;
    logic [127:0] wdata0 = '0;
    logic [31:0] rdata0, din0, dout0;
    logic        busy0, en0;
    logic [0:0]  ramwe0;
    logic [9:0]  ramaddr0;
    logic [31:0] mem0 [1024];

    gnrc_ram_arbiter #(.NREQ(4), .DW(32), .AW(10), .DELAY(1), .BYTE_WRITE(0)) dut0 (
        .clk_i(clk), .rst_i(rst0), .req_valid_i(valid0), .req_ready_o(ready0),
        .req_we_i(we0), .req_addr_i(addr0), .req_wdata_i(wdata0),
        .rsp_valid_o(rsp0), .rsp_rdata_o(rdata0), .busy_o(busy0),
        .ram_en_o(en0), .ram_we_o(ramwe0), .ram_addr_o(ramaddr0), .ram_din_o(din0),
        .ram_dout_i(dout0)
    );

    always @(posedge clk) begin
        if (en0) begin
            if (ramwe0[0]) mem0[ramaddr0] <= din0;
            dout0 <= mem0[ramaddr0];
        end
    end

    // ---------------- instance 1: NREQ=3, DELAY=2, byte write ----------------
    logic        rst1 = 1'b1;
    logic [2:0]  valid1 = '0, ready1, rsp1;
    logic [11:0] we1 = '0;
    logic [29:0] addr1 = '0;
    logic [95:0] wdata1 = '0;
    logic [31:0] rdata1, din1, dout1, dstage1;
    logic        busy1, en1;
    logic [3:0]  ramwe1;
    logic [9:0]  ramaddr1;
    logic [31:0] mem1 [1024];

    gnrc_ram_arbiter #(.NREQ(3), .DW(32), .AW(10), .DELAY(2), .BYTE_WRITE(1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .req_valid_i(valid1), .req_ready_o(ready1),
        .req_we_i(we1), .req_addr_i(addr1), .req_wdata_i(wdata1),
        .rsp_valid_o(rsp1), .rsp_rdata_o(rdata1), .busy_o(busy1),
        .ram_en_o(en1), .ram_we_o(ramwe1), .ram_addr_o(ramaddr1), .ram_din_o(din1),
        .ram_dout_i(dout1)
    );

    always @(posedge clk) begin
        if (en1) begin
            for (int b = 0; b < 4; b++)
                if (ramwe1[b]) mem1[ramaddr1][8*b +: 8] <= din1[8*b +: 8];
            dstage1 <= mem1[ramaddr1];
        end
        dout1 <= dstage1;
    end

    initial begin
        for (int a = 0; a < 1024; a++) begin
            mem0[a] = 32'hC0DE0000 | 32'(a);
            mem1[a] = 32'hC0DE0000 | 32'(a);
        end
    end

    // Requester i presents address base+16*i and write data wdata+i.
    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [9:0]  base;
        logic [31:0] wdata;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rsp;
        logic        exp_busy;
        logic        exp_en;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] we,
                                input logic [9:0] base, input logic [31:0] wdata,
                                input logic [3:0] exp_ready, input logic [3:0] exp_rsp,
                                input logic exp_busy, input logic exp_en,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.rst = rst; v.valid = valid; v.we = we; v.base = base; v.wdata = wdata;
        v.exp_ready = exp_ready; v.exp_rsp = exp_rsp; v.exp_busy = exp_busy;
        v.exp_en = exp_en; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic drive1(input logic rst, input logic [2:0] valid, input logic [11:0] we,
                          input logic [9:0] base, input logic [31:0] wdata);
        rst1 = rst;
        valid1 = valid;
        we1 = we;
        for (int i = 0; i < 3; i++) begin
            addr1[i*10 +: 10]  = base + 10'(16 * i);
            wdata1[i*32 +: 32] = wdata + 32'(i);
        end
    endtask

    initial begin
        //                rst valid we    base    wdata          rdy   rsp   busy en  rdata
        vecs[0]  = mk(1, 4'hF, 4'h0, 10'h10, 32'h0,        4'h0, 4'h0, 0, 0, 32'h0);
        vecs[1]  = mk(1, 4'hF, 4'h0, 10'h10, 32'h0,        4'h0, 4'h0, 0, 0, 32'h0);
        vecs[2]  = mk(1, 4'hF, 4'h0, 10'h10, 32'h0,        4'h0, 4'h0, 0, 0, 32'h0);
        vecs[3]  = mk(0, 4'hF, 4'h0, 10'h10, 32'h0,        4'h1, 4'h0, 0, 1, 32'h0);
        vecs[4]  = mk(0, 4'hF, 4'h0, 10'h10, 32'h0,        4'h2, 4'h1, 1, 1, 32'hC0DE0010);
        vecs[5]  = mk(0, 4'hF, 4'h0, 10'h10, 32'h0,        4'h4, 4'h2, 1, 1, 32'hC0DE0020);
        vecs[6]  = mk(0, 4'hF, 4'h0, 10'h10, 32'h0,        4'h8, 4'h4, 1, 1, 32'hC0DE0030);
        vecs[7]  = mk(0, 4'hF, 4'h0, 10'h10, 32'h0,        4'h1, 4'h8, 1, 1, 32'hC0DE0040);
        vecs[8]  = mk(0, 4'hF, 4'h0, 10'h10, 32'h0,        4'h2, 4'h1, 1, 1, 32'hC0DE0010);
        vecs[9]  = mk(0, 4'h0, 4'h0, 10'h10, 32'h0,        4'h0, 4'h2, 1, 0, 32'hC0DE0020);
        vecs[10] = mk(0, 4'h0, 4'h0, 10'h10, 32'h0,        4'h0, 4'h0, 0, 0, 32'h0);
        vecs[11] = mk(0, 4'hA, 4'h0, 10'h10, 32'h0,        4'h8, 4'h0, 0, 1, 32'h0);
        vecs[12] = mk(0, 4'h2, 4'h0, 10'h10, 32'h0,        4'h2, 4'h8, 1, 1, 32'hC0DE0040);
        vecs[13] = mk(0, 4'h0, 4'h0, 10'h10, 32'h0,        4'h0, 4'h2, 1, 0, 32'hC0DE0020);
        vecs[14] = mk(0, 4'h1, 4'h1, 10'h02, 32'h111111F2, 4'h1, 4'h0, 0, 1, 32'h0);
        vecs[15] = mk(0, 4'h1, 4'h0, 10'h02, 32'h0,        4'h1, 4'h0, 0, 1, 32'h0);
        vecs[16] = mk(0, 4'h0, 4'h0, 10'h02, 32'h0,        4'h0, 4'h1, 1, 0, 32'h111111F2);
        vecs[17] = mk(0, 4'h0, 4'h0, 10'h02, 32'h0,        4'h0, 4'h0, 0, 0, 32'h0);

        for (int n = 0; n < NV; n++) begin
            tick();
            rst0 = vecs[n].rst;
            valid0 = vecs[n].valid;
            we0 = vecs[n].we;
            for (int i = 0; i < 4; i++) begin
                addr0[i*10 +: 10]  = vecs[n].base + 10'(16 * i);
                wdata0[i*32 +: 32] = vecs[n].wdata + 32'(i);
            end
            #5;
            check($sformatf("v%0d ready", n), 32'(ready0), 32'(vecs[n].exp_ready));
            check($sformatf("v%0d rsp_valid", n), 32'(rsp0), 32'(vecs[n].exp_rsp));
            check($sformatf("v%0d busy", n), 32'(busy0), 32'(vecs[n].exp_busy));
            check($sformatf("v%0d ram_en", n), 32'(en0), 32'(vecs[n].exp_en));
            if (vecs[n].exp_rsp != 4'h0)
                check($sformatf("v%0d rdata", n), rdata0, vecs[n].exp_rdata);
            if (vecs[n].exp_ready != 4'h0) begin
                for (int i = 0; i < 4; i++) begin
                    if (vecs[n].exp_ready[i]) begin
                        check($sformatf("v%0d ram_addr", n), 32'(ramaddr0),
                              32'(vecs[n].base + 10'(16 * i)));
                        check($sformatf("v%0d ram_we", n), 32'(ramwe0), 32'(vecs[n].we[i]));
                        check($sformatf("v%0d ram_din", n), din0, vecs[n].wdata + 32'(i));
                    end
                end
            end else begin
                check($sformatf("v%0d ram_we idle", n), 32'(ramwe0), 32'h0);
            end
        end
        valid0 = '0;

        // Byte-write merge on addr 2, then read back with DELAY=2.
        tick(); drive1(0, 3'b001, 12'h00F, 10'h02, 32'h111111F2); #5;
        check("b1 ready", 32'(ready1), 32'h1);
        check("b1 ram_we", 32'(ramwe1), 32'hF);
        check("b1 ram_addr", 32'(ramaddr1), 32'h2);
        check("b1 ram_din", din1, 32'h111111F2);
        tick(); drive1(0, 3'b001, 12'h001, 10'h02, 32'h00000088); #5;
        check("b2 ready", 32'(ready1), 32'h1);
        check("b2 ram_we", 32'(ramwe1), 32'h1);
        check("b2 ram_din", din1, 32'h00000088);
        tick(); drive1(0, 3'b001, 12'h000, 10'h02, 32'h0); #5;
        check("b3 ready", 32'(ready1), 32'h1);
        check("b3 ram_we", 32'(ramwe1), 32'h0);
        check("b3 busy", 32'(busy1), 32'h0);
        tick(); drive1(0, 3'b000, 12'h000, 10'h02, 32'h0); #5;
        check("b4 busy", 32'(busy1), 32'h1);
        check("b4 rsp_valid", 32'(rsp1), 32'h0);
        check("b4 ram_en", 32'(en1), 32'h0);
        tick(); #5;
        check("b5 rsp_valid", 32'(rsp1), 32'h1);
        check("b5 rdata merged", rdata1, 32'h11111188);
        check("b5 busy", 32'(busy1), 32'h1);
        tick(); #5;
        check("b6 rsp_valid", 32'(rsp1), 32'h0);
        check("b6 busy", 32'(busy1), 32'h0);

        // Pointer wrap 2 -> 0 with NREQ=3, responses in issue order two cycles later.
        tick(); drive1(0, 3'b111, 12'h000, 10'h10, 32'h0); #5;
        check("w1 ready", 32'(ready1), 32'h2);
        tick(); drive1(0, 3'b101, 12'h000, 10'h10, 32'h0); #5;
        check("w2 ready", 32'(ready1), 32'h4);
        check("w2 rsp_valid", 32'(rsp1), 32'h0);
        tick(); drive1(0, 3'b001, 12'h000, 10'h10, 32'h0); #5;
        check("w3 ready wrap", 32'(ready1), 32'h1);
        check("w3 rsp_valid", 32'(rsp1), 32'h2);
        check("w3 rdata", rdata1, 32'hC0DE0020);
        tick(); drive1(0, 3'b000, 12'h000, 10'h10, 32'h0); #5;
        check("w4 rsp_valid", 32'(rsp1), 32'h4);
        check("w4 rdata", rdata1, 32'hC0DE0030);
        tick(); #5;
        check("w5 rsp_valid", 32'(rsp1), 32'h1);
        check("w5 rdata", rdata1, 32'hC0DE0010);
        check("w5 busy", 32'(busy1), 32'h1);
        tick(); #5;
        check("w6 rsp_valid", 32'(rsp1), 32'h0);
        check("w6 busy", 32'(busy1), 32'h0);

        // Reset one cycle after a read accept discards it; request during reset is refused.
        tick(); drive1(0, 3'b001, 12'h000, 10'h10, 32'h0); #5;
        check("r1 ready", 32'(ready1), 32'h1);
        tick(); drive1(1, 3'b010, 12'h000, 10'h10, 32'h0); #5;
        check("r2 ready in reset", 32'(ready1), 32'h0);
        check("r2 ram_en in reset", 32'(en1), 32'h0);
        check("r2 ram_we in reset", 32'(ramwe1), 32'h0);
        check("r2 busy in reset", 32'(busy1), 32'h0);
        tick(); drive1(0, 3'b000, 12'h000, 10'h10, 32'h0); #5;
        check("r3 rsp_valid dropped", 32'(rsp1), 32'h0);
        check("r3 busy", 32'(busy1), 32'h0);
        tick(); drive1(0, 3'b111, 12'h000, 10'h10, 32'h0); #5;
        check("r4 ready after reset", 32'(ready1), 32'h1);
        tick(); drive1(0, 3'b000, 12'h000, 10'h10, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
